// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry look-ahead slice fed a nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining SIGNED_OVF_EN.

module cla4_slice (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c
);
   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;

   always_comb begin
      w_p    = i_a ^ i_b;
      w_g    = i_a & i_b;
      w_c[0] = i_c;
      w_c[1] = w_g[0] | (w_p[0] & i_c);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & i_c);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
      o_s    = w_p ^ w_c[3:0];
      o_c    = w_c[4];
   end
endmodule

module cla_nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       w_s;
   logic             w_co;
   logic             w_last;
   logic [WIDTH-1:0] w_acc_next;
`ifdef SIGNED_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   cla4_slice u_slice (
      .i_a (r_a_sh[3:0]),
      .i_b (r_b_sh[3:0]),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_co)
   );

   // Shift via concatenation so WIDTH=4 needs no zero-width slice of r_acc.
   assign w_acc_next = WIDTH'({w_s, r_acc} >> 4);
   assign w_last     = (r_cnt == CW'(NIBBLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
`ifdef SIGNED_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a_sh  <= a;
               r_b_sh  <= b;
               r_carry <= cin;
               r_cnt   <= '0;
`ifdef SIGNED_OVF_EN
               r_a_msb <= a[WIDTH-1];
               r_b_msb <= b[WIDTH-1];
`endif
            end
            RUN: begin
               r_a_sh  <= r_a_sh >> 4;
               r_b_sh  <= r_b_sh >> 4;
               r_carry <= w_co;
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_sum  <= w_acc_next;
                  r_cout <= w_co;
`ifdef SIGNED_OVF_EN
                  r_ovf  <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
`ifdef SIGNED_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed self-checking bench for cla_nibble_serial_adder (WIDTH=16).
// Overflow checks are compiled in when SIGNED_OVF_EN is defined.

module tb_cla_nibble_serial_adder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
`ifdef SIGNED_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   cla_nibble_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SIGNED_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Present operands, return edges from accept to out_valid (0 on timeout); leaves DUT in DONE.
   task automatic run_op(input logic [15:0] t_a, input logic [15:0] t_b, input logic t_c,
                         input bit keep_valid, output int lat);
      lat = 0;
      @(negedge clk);
      a = t_a; b = t_b; cin = t_c; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!keep_valid) in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         if (i == 1) begin @(posedge clk); #1; end
         if (out_valid === 1'b1) begin lat = i; break; end
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b, required 0 0 0000 0",
                  in_ready, out_valid, sum, cout);
      end
`ifdef SIGNED_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add();
      logic [15:0] va [6] = '{16'h0001, 16'hFFFF, 16'h000B, 16'hABCD, 16'h8000, 16'hFFFF};
      logic [15:0] vb [6] = '{16'h0000, 16'h0001, 16'h0006, 16'h1234, 16'h8000, 16'hFFFF};
      logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] es [6] = '{16'h0001, 16'h0000, 16'h0012, 16'hBE01, 16'h0000, 16'hFFFF};
      logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int lat;
      for (int k = 0; k < 6; k++) begin
         run_op(va[k], vb[k], vc[k], 1'b0, lat);
         checks++;
         if (lat != 4) begin
            errors++; $display("FAIL add_latency[%0d]: got %0d edges want 4", k, lat);
         end
         checks++;
         if (sum !== es[k] || cout !== ec[k]) begin
            errors++;
            $display("FAIL add_result[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                     k, sum, cout, es[k], ec[k]);
         end
         finish_op();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== es[k] || cout !== ec[k]) begin
            errors++;
            $display("FAIL add_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b want 0 1 %h %b",
                     k, out_valid, in_ready, sum, cout, es[k], ec[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b0;
      run_op(16'h1357, 16'h2468, 1'b0, 1'b1, lat);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (sum !== 16'h37BF || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall[%0d]: sum=%h cout=%b out_valid=%b in_ready=%b want 37bf 0 1 0",
                     i, sum, cout, out_valid, in_ready);
         end
         @(posedge clk); #1;
      end
      a = 16'hF100; b = 16'h1000; cin = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle_cycle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: in_ready=%b want 0", in_ready); end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin lat = i; break; end
      end
      checks++;
      if (lat != 4 || sum !== 16'h0100 || cout !== 1'b1) begin
         errors++;
         $display("FAIL bp_second_op: lat=%0d sum=%h cout=%b want 4 0100 1", lat, sum, cout);
      end
      finish_op();
   endtask

   task automatic test_reset_midrun();
      int lat;
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_async_reset: out_valid=%b sum=%h cout=%b in_ready=%b want 0 0000 0 0",
                  out_valid, sum, cout, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_no_pulse[%0d]: out_valid=%b want 0", i, out_valid);
         end
      end
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 4 || sum !== 16'h2345 || cout !== 1'b0) begin
         errors++;
         $display("FAIL midrun_fresh_op: lat=%0d sum=%h cout=%b want 4 2345 0", lat, sum, cout);
      end
      finish_op();
   endtask

`ifdef SIGNED_OVF_EN
   task automatic test_ovf();
      logic [15:0] va [3] = '{16'h7FFF, 16'hFFFF, 16'h8000};
      logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h8000};
      logic [15:0] es [3] = '{16'h8000, 16'hFFFE, 16'h0000};
      logic        ec [3] = '{1'b0, 1'b1, 1'b1};
      logic        eo [3] = '{1'b1, 1'b0, 1'b1};
      int lat;
      for (int k = 0; k < 3; k++) begin
         run_op(va[k], vb[k], 1'b0, 1'b0, lat);
         checks++;
         if (lat != 4 || sum !== es[k] || cout !== ec[k] || ovf !== eo[k]) begin
            errors++;
            $display("FAIL ovf[%0d]: lat=%0d sum=%h cout=%b ovf=%b want 4 %h %b %b",
                     k, lat, sum, cout, ovf, es[k], ec[k], eo[k]);
         end
         finish_op();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_reset_midrun();
`ifdef SIGNED_OVF_EN
      test_ovf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
